// File: rtl/mem_io_responder.sv
// Byte-wide CPU memory responder: 2^RAM_AW-byte RAM plus UART FIFOs, cycle counter and stop port at 0x30000.
// Latency: reads return on cpu_rdata one cycle after the address; writes land at the end of the issuing cycle.
// Backpressure: none toward the CPU (rdy_in stalls it); io_buffer_full warns 2 entries early; TX pushes while full are dropped.

// Small byte FIFO shared by the TX and RX paths.
// Latency: a push is visible at head_dat one cycle later; a pop retires the head at the clock edge.
// Backpressure: pushes while full are dropped and pops while empty are ignored; the caller sees full/empty.
module mem_io_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       push_vld,
    input  logic [7:0]                 push_dat,
    input  logic                       pop_vld,
    output logic [7:0]                 head_dat,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push_vld && !full;
    assign pop_ok   = pop_vld && !empty;
    assign head_dat = mem[rd_ptr];

    // Storage is not reset; only the pointers and count define validity.
    always_ff @(posedge clk_in) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally; the count only moves when exactly one side acts.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module mem_io_responder #(
    parameter int RAM_AW   = 17,
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] cpu_a,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        program_done,
    output logic        tx_overflow
);
    localparam int          TX_AW    = $clog2(TX_DEPTH);
    localparam int          RX_AW    = $clog2(RX_DEPTH);
    localparam logic [17:0] ADDR_UART = 18'h30000;
    localparam logic [17:0] ADDR_CNT  = 18'h30004;

    logic [17:0]     addr;
    logic            is_io;
    logic            is_uart;
    logic            is_cnt_any;
    logic            is_cnt0;
    logic            ram_we;
    logic            tx_push_req;
    logic [7:0]      tx_push_dat;
    logic            rx_pop_req;
    logic [TX_AW:0]  tx_count;
    logic            tx_full;
    logic            tx_empty;
    logic [7:0]      rx_head;
    logic [RX_AW:0]  rx_count_unused;
    logic            rx_full;
    logic            rx_empty;
    logic [31:0]     cycle_cnt;
    logic [31:0]     snapshot;
    logic [7:0]      ram [2**RAM_AW];
    logic [7:0]      ram_rd_q;
    logic [7:0]      io_rdata_q;
    logic [7:0]      io_rdata_nxt;
    logic            sel_ram_q;
    logic            unused_addr_hi;

    // Only the low 18 address bits are decoded; the rest are don't-care.
    assign addr           = cpu_a[17:0];
    assign unused_addr_hi = ^cpu_a[31:18];
    assign is_io          = (addr[17:16] == 2'b11);
    assign is_uart        = (addr == ADDR_UART);
    assign is_cnt_any     = (addr[17:2] == ADDR_CNT[17:2]);
    assign is_cnt0        = (addr == ADDR_CNT);

    assign ram_we      = rdy_in && cpu_wr && !is_io;
    // A zero byte to the UART port is filtered; the stop port pushes 0x00 as an end marker.
    assign tx_push_req = rdy_in && cpu_wr && !program_done &&
                         ((is_uart && (cpu_wdata != 8'h00)) || is_cnt0);
    assign tx_push_dat = is_cnt0 ? 8'h00 : cpu_wdata;
    assign rx_pop_req  = rdy_in && !cpu_wr && is_uart;

    mem_io_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .push_vld (tx_push_req),
        .push_dat (tx_push_dat),
        .pop_vld  (tx_ready),
        .head_dat (tx_data),
        .count    (tx_count),
        .full     (tx_full),
        .empty    (tx_empty)
    );

    mem_io_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .push_vld (rx_valid),
        .push_dat (rx_data),
        .pop_vld  (rx_pop_req),
        .head_dat (rx_head),
        .count    (rx_count_unused),
        .full     (rx_full),
        .empty    (rx_empty)
    );

    assign tx_valid       = !tx_empty;
    assign rx_ready       = !rx_full;
    // Two-entry margin absorbs CPU writes already in flight when the flag is seen.
    assign io_buffer_full = (tx_count >= (TX_AW+1)'(TX_DEPTH - 2));

    // RAM array: write-through at the edge, registered read; contents survive reset.
    always_ff @(posedge clk_in) begin
        if (ram_we) begin
            ram[cpu_a[RAM_AW-1:0]] <= cpu_wdata;
        end
        if (rdy_in) begin
            ram_rd_q <= ram[cpu_a[RAM_AW-1:0]];
        end
    end

    // I/O read data; reading 0x30004 returns byte 0 of the live counter it is snapshotting.
    always_comb begin
        io_rdata_nxt = 8'h00;
        if (is_uart) begin
            io_rdata_nxt = rx_empty ? 8'h00 : rx_head;
        end else if (is_cnt_any) begin
            case (addr[1:0])
                2'd0:    io_rdata_nxt = cycle_cnt[7:0];
                2'd1:    io_rdata_nxt = snapshot[15:8];
                2'd2:    io_rdata_nxt = snapshot[23:16];
                default: io_rdata_nxt = snapshot[31:24];
            endcase
        end
    end

    // Read-side registers; reset selects the I/O register so cpu_rdata clears without a clock.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sel_ram_q  <= 1'b0;
            io_rdata_q <= 8'h00;
        end else if (rdy_in) begin
            sel_ram_q  <= !is_io;
            io_rdata_q <= io_rdata_nxt;
        end
    end

    assign cpu_rdata = sel_ram_q ? ram_rd_q : io_rdata_q;

    // Cycle counter and coherent snapshot, both frozen while the CPU is stalled.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cycle_cnt <= 32'd0;
            snapshot  <= 32'd0;
        end else if (rdy_in) begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (!cpu_wr && is_cnt0) begin
                snapshot <= cycle_cnt;
            end
        end
    end

    // Sticky status: stop request and dropped-byte indication.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            program_done <= 1'b0;
            tx_overflow  <= 1'b0;
        end else begin
            if (rdy_in && cpu_wr && is_cnt0) begin
                program_done <= 1'b1;
            end
            if (tx_push_req && tx_full) begin
                tx_overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_io_responder.sv
module tb_mem_io_responder;
    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic [31:0] cpu_a;
    logic        cpu_wr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        program_done;
    logic        tx_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    mem_io_responder dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .cpu_a          (cpu_a),
        .cpu_wr         (cpu_wr),
        .cpu_wdata      (cpu_wdata),
        .cpu_rdata      (cpu_rdata),
        .io_buffer_full (io_buffer_full),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .program_done   (program_done),
        .tx_overflow    (tx_overflow)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // One bus access: called at a negedge, returns at the next negedge.
    task automatic cyc(input logic wr, input logic [31:0] a, input logic [7:0] d);
        rdy_in    = 1'b1;
        cpu_wr    = wr;
        cpu_a     = a;
        cpu_wdata = d;
        @(negedge clk_in);
    endtask

    task automatic do_reset();
        rdy_in = 1'b0;
        cpu_wr = 1'b0;
        rst_in = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (cpu_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h want 00", cpu_rdata); end
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
        n_checks++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_rx_ready: got %b want 1", rx_ready); end
        n_checks++; if (io_buffer_full !== 1'b0) begin n_fail++; $display("FAIL reset_buf_full: got %b want 0", io_buffer_full); end
        n_checks++; if (program_done !== 1'b0) begin n_fail++; $display("FAIL reset_prog_done: got %b want 0", program_done); end
        n_checks++; if (tx_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_tx_ovf: got %b want 0", tx_overflow); end
    endtask

    task automatic test_ram();
        cyc(1'b1, 32'h0000_0123, 8'hA5);
        cyc(1'b0, 32'h0003_0008, 8'h00);
        n_checks++; if (cpu_rdata !== 8'h00) begin n_fail++; $display("FAIL io_other_rd: got %h want 00", cpu_rdata); end
        cyc(1'b0, 32'h0000_0123, 8'h00);
        n_checks++; if (cpu_rdata !== 8'hA5) begin n_fail++; $display("FAIL ram_rd_123: got %h want a5", cpu_rdata); end
        cyc(1'b1, 32'h0000_0124, 8'h3C);
        cyc(1'b0, 32'h0000_0124, 8'h00);
        n_checks++; if (cpu_rdata !== 8'h3C) begin n_fail++; $display("FAIL ram_wr_then_rd: got %h want 3c", cpu_rdata); end
        cyc(1'b1, 32'h0002_FFFF, 8'h5A);
        cyc(1'b1, 32'h0003_0008, 8'hFF);
        cyc(1'b0, 32'h0002_FFFF, 8'h00);
        n_checks++; if (cpu_rdata !== 8'h5A) begin n_fail++; $display("FAIL ram_rd_top: got %h want 5a", cpu_rdata); end
        cyc(1'b0, 32'h0003_0008, 8'h00);
        n_checks++; if (cpu_rdata !== 8'h00) begin n_fail++; $display("FAIL io_other_wr_ignored: got %h want 00", cpu_rdata); end
        cyc(1'b0, 32'hFFFC_0123, 8'h00);
        n_checks++; if (cpu_rdata !== 8'hA5) begin n_fail++; $display("FAIL ram_hi_bits_ignored: got %h want a5", cpu_rdata); end
        rdy_in = 1'b0;
    endtask

    task automatic test_tx_filter();
        tx_ready = 1'b1;
        cyc(1'b1, 32'h0003_0000, 8'h41);
        n_checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin n_fail++; $display("FAIL tx_first: valid=%b data=%h want 1/41", tx_valid, tx_data); end
        cyc(1'b1, 32'h0003_0000, 8'h00);
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL tx_zero_filtered: valid=%b want 0", tx_valid); end
        cyc(1'b1, 32'h0003_0000, 8'h42);
        n_checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h42) begin n_fail++; $display("FAIL tx_second: valid=%b data=%h want 1/42", tx_valid, tx_data); end
        cyc(1'b1, 32'h0003_0004, 8'h77);
        n_checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h00) begin n_fail++; $display("FAIL tx_stop_byte: valid=%b data=%h want 1/00", tx_valid, tx_data); end
        n_checks++; if (program_done !== 1'b1) begin n_fail++; $display("FAIL prog_done_set: got %b want 1", program_done); end
        cyc(1'b1, 32'h0003_0000, 8'h43);
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL tx_after_done: valid=%b want 0", tx_valid); end
        n_checks++; if (tx_overflow !== 1'b0) begin n_fail++; $display("FAIL tx_ovf_clear: got %b want 0", tx_overflow); end
        rdy_in   = 1'b0;
        tx_ready = 1'b0;
    endtask

    task automatic test_tx_overflow();
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 32'h0003_0000, 8'(8'h80 + i));
            if (i == 12) begin
                n_checks++; if (io_buffer_full !== 1'b0) begin n_fail++; $display("FAIL buf_full_13: got %b want 0", io_buffer_full); end
            end
            if (i == 13) begin
                n_checks++; if (io_buffer_full !== 1'b1) begin n_fail++; $display("FAIL buf_full_14: got %b want 1", io_buffer_full); end
            end
            if (i == 15) begin
                n_checks++; if (tx_overflow !== 1'b0) begin n_fail++; $display("FAIL tx_ovf_16: got %b want 0", tx_overflow); end
            end
        end
        cyc(1'b1, 32'h0003_0000, 8'hEE);
        n_checks++; if (tx_overflow !== 1'b1) begin n_fail++; $display("FAIL tx_ovf_17: got %b want 1", tx_overflow); end
        rdy_in   = 1'b0;
        tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (tx_valid !== 1'b1 || tx_data !== 8'(8'h80 + i)) begin
                n_fail++; $display("FAIL tx_drain_%0d: valid=%b data=%h want 1/%h", i, tx_valid, tx_data, 8'(8'h80 + i));
            end
            @(negedge clk_in);
        end
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL tx_drained_empty: valid=%b want 0", tx_valid); end
        n_checks++; if (io_buffer_full !== 1'b0) begin n_fail++; $display("FAIL buf_full_drained: got %b want 0", io_buffer_full); end
        n_checks++; if (tx_overflow !== 1'b1) begin n_fail++; $display("FAIL tx_ovf_sticky: got %b want 1", tx_overflow); end
        tx_ready = 1'b0;
    endtask

    task automatic test_rx();
        rdy_in   = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 8'h11;
        @(negedge clk_in);
        rx_data  = 8'h22;
        @(negedge clk_in);
        rx_valid = 1'b0;
        cyc(1'b0, 32'h0003_0000, 8'h00);
        n_checks++; if (cpu_rdata !== 8'h11) begin n_fail++; $display("FAIL rx_rd1: got %h want 11", cpu_rdata); end
        cyc(1'b0, 32'h0003_0000, 8'h00);
        n_checks++; if (cpu_rdata !== 8'h22) begin n_fail++; $display("FAIL rx_rd2: got %h want 22", cpu_rdata); end
        cyc(1'b0, 32'h0003_0000, 8'h00);
        n_checks++; if (cpu_rdata !== 8'h00) begin n_fail++; $display("FAIL rx_rd_empty: got %h want 00", cpu_rdata); end
        // Count 1, then push and pop in the same cycle.
        rdy_in   = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 8'h33;
        @(negedge clk_in);
        rx_data  = 8'h44;
        cyc(1'b0, 32'h0003_0000, 8'h00);
        rx_valid = 1'b0;
        n_checks++; if (cpu_rdata !== 8'h33) begin n_fail++; $display("FAIL rx_simul_pop: got %h want 33", cpu_rdata); end
        cyc(1'b0, 32'h0003_0000, 8'h00);
        n_checks++; if (cpu_rdata !== 8'h44) begin n_fail++; $display("FAIL rx_simul_push: got %h want 44", cpu_rdata); end
        cyc(1'b0, 32'h0003_0000, 8'h00);
        n_checks++; if (cpu_rdata !== 8'h00) begin n_fail++; $display("FAIL rx_simul_count: got %h want 00", cpu_rdata); end
        // Fill to capacity.
        rdy_in   = 1'b0;
        rx_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rx_data = 8'(8'h60 + i);
            @(negedge clk_in);
            if (i == 14) begin
                n_checks++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL rx_ready_15: got %b want 1", rx_ready); end
            end
            if (i == 15) begin
                n_checks++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL rx_ready_16: got %b want 0", rx_ready); end
            end
        end
        rx_data = 8'hFF;
        @(negedge clk_in);
        rx_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 32'h0003_0000, 8'h00);
            n_checks++;
            if (cpu_rdata !== 8'(8'h60 + i)) begin
                n_fail++; $display("FAIL rx_full_rd_%0d: got %h want %h", i, cpu_rdata, 8'(8'h60 + i));
            end
        end
        cyc(1'b0, 32'h0003_0000, 8'h00);
        n_checks++; if (cpu_rdata !== 8'h00) begin n_fail++; $display("FAIL rx_extra_dropped: got %h want 00", cpu_rdata); end
        n_checks++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL rx_ready_after: got %b want 1", rx_ready); end
        rdy_in = 1'b0;
    endtask

    task automatic test_cycle_cnt();
        do_reset();
        for (int i = 0; i < 1000; i++) begin
            if (i >= 400 && i < 500) begin
                rdy_in = 1'b0;
                cpu_wr = 1'b0;
                cpu_a  = 32'h0003_0008;
                @(negedge clk_in);
                n_checks++;
                if (cpu_rdata !== 8'hA5) begin n_fail++; $display("FAIL rdata_hold_%0d: got %h want a5", i, cpu_rdata); end
            end else if (i == 399) begin
                cyc(1'b0, 32'h0000_0123, 8'h00);
            end else begin
                cyc(1'b0, 32'h0003_0008, 8'h00);
            end
        end
        cyc(1'b0, 32'h0003_0004, 8'h00);
        n_checks++; if (cpu_rdata !== 8'h84) begin n_fail++; $display("FAIL cnt_b0: got %h want 84", cpu_rdata); end
        cyc(1'b0, 32'h0003_0005, 8'h00);
        n_checks++; if (cpu_rdata !== 8'h03) begin n_fail++; $display("FAIL cnt_b1: got %h want 03", cpu_rdata); end
        cyc(1'b0, 32'h0003_0006, 8'h00);
        n_checks++; if (cpu_rdata !== 8'h00) begin n_fail++; $display("FAIL cnt_b2: got %h want 00", cpu_rdata); end
        cyc(1'b0, 32'h0003_0007, 8'h00);
        n_checks++; if (cpu_rdata !== 8'h00) begin n_fail++; $display("FAIL cnt_b3: got %h want 00", cpu_rdata); end
        cyc(1'b0, 32'h0003_0004, 8'h00);
        n_checks++; if (cpu_rdata !== 8'h88) begin n_fail++; $display("FAIL cnt_resnap_b0: got %h want 88", cpu_rdata); end
        cyc(1'b0, 32'h0003_0005, 8'h00);
        n_checks++; if (cpu_rdata !== 8'h03) begin n_fail++; $display("FAIL cnt_resnap_b1: got %h want 03", cpu_rdata); end
        rdy_in = 1'b0;
    endtask

    task automatic test_reset_midburst();
        tx_ready = 1'b0;
        cyc(1'b1, 32'h0003_0000, 8'h51);
        cyc(1'b1, 32'h0003_0000, 8'h52);
        cyc(1'b0, 32'h0000_0123, 8'h00);
        n_checks++; if (cpu_rdata !== 8'hA5 || tx_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset: rdata=%h valid=%b want a5/1", cpu_rdata, tx_valid); end
        rdy_in    = 1'b1;
        cpu_wr    = 1'b1;
        cpu_a     = 32'h0003_0000;
        cpu_wdata = 8'h53;
        @(posedge clk_in);
        #3;
        rst_in = 1'b1;
        #1;
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL async_rst_tx_valid: got %b want 0", tx_valid); end
        n_checks++; if (cpu_rdata !== 8'h00) begin n_fail++; $display("FAIL async_rst_rdata: got %h want 00", cpu_rdata); end
        n_checks++; if (rx_ready !== 1'b1 || io_buffer_full !== 1'b0) begin n_fail++; $display("FAIL async_rst_flags: rx_ready=%b buf_full=%b want 1/0", rx_ready, io_buffer_full); end
        @(negedge clk_in);
        rdy_in = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b0;
        cyc(1'b0, 32'h0000_0123, 8'h00);
        n_checks++; if (cpu_rdata !== 8'hA5) begin n_fail++; $display("FAIL ram_kept_123: got %h want a5", cpu_rdata); end
        cyc(1'b0, 32'h0000_0124, 8'h00);
        n_checks++; if (cpu_rdata !== 8'h3C) begin n_fail++; $display("FAIL ram_kept_124: got %h want 3c", cpu_rdata); end
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL tx_empty_after_rst: got %b want 0", tx_valid); end
        rdy_in = 1'b0;
    endtask

    initial begin
        rst_in    = 1'b1;
        rdy_in    = 1'b0;
        cpu_a     = 32'h0;
        cpu_wr    = 1'b0;
        cpu_wdata = 8'h00;
        tx_ready  = 1'b0;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        @(negedge clk_in);
        test_reset();
        test_ram();
        test_tx_filter();
        test_tx_overflow();
        test_rx();
        test_cycle_cnt();
        test_reset_midburst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached after %0d checks", n_checks);
        $fatal(1, "watchdog");
    end
endmodule
